// File: rtl/kb_pkg.sv
// ---------------------------------------------------------------------------
// kb_pkg -- shared constants and types for the PS/2 keyboard scan FIFO.
//
// Contents:
//   OFS_*        offsets of the four read ports above BASE_PORT
//   PFX_EXT/BRK  PS/2 set-2 prefix bytes (E0 extended, F0 break)
//   ID_BYTE      constant returned at BASE_PORT+3
//   dec_state_t  prefix decoder state
//   kb_entry_t   10-bit FIFO entry {ext, brk, code}
//   sat_cnt4     saturates an entry count to the 4-bit status field
// ---------------------------------------------------------------------------
package kb_pkg;

    localparam logic [7:0] OFS_DATA   = 8'd0;
    localparam logic [7:0] OFS_FLAGS  = 8'd1;
    localparam logic [7:0] OFS_STATUS = 8'd2;
    localparam logic [7:0] OFS_CTRL   = 8'd3;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    localparam logic [7:0] ID_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXT    = 2'd1,
        BRK    = 2'd2,
        EXTBRK = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kb_entry_t;

    // The status register has only four count bits; a 16-deep FIFO holding
    // 16 entries reports 15.
    function automatic logic [3:0] sat_cnt4(input logic [4:0] cnt);
        return (cnt > 5'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx -- PS/2 device-to-host frame receiver.
//
// Synchronises both PS/2 lines, glitch-filters the clock, samples data on
// each filtered falling edge and assembles 11-bit frames
// (start 0, 8 data LSB first, odd parity, stop 1).
//
// Ports:
//   i_clk, i_rst_n     system clock, asynchronous active-low reset
//   i_ps2_clk          raw PS/2 clock (asynchronous)
//   i_ps2_data         raw PS/2 data (asynchronous)
//   o_byte             last good data byte
//   o_byte_valid       one-cycle pulse: o_byte holds a good byte
//   o_err              one-cycle pulse: parity or stop bit was wrong
//
// A frame with a bad start bit is silently ignored. If TIMEOUT_CYC cycles
// pass without a falling edge while a frame is in progress, the partial
// frame is dropped without any error indication.
// ---------------------------------------------------------------------------
module ps2_frame_rx #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int FILTER_LEN  = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_err
);

    localparam int FW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          r_clk_s1, r_clk_s2;
    logic          r_dat_s1, r_dat_s2;
    logic          r_filt;
    logic          r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic [3:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_byte;
    logic          r_byte_valid;
    logic          r_err;

    logic          w_fall;
    logic          w_frame_ok;

    // Two-flop synchronisers on both lines.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered clock flips only after FILTER_LEN consecutive samples
    // that disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_clk_s2 != r_filt) begin
                if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                    r_filt <= r_clk_s2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_fall = r_filt_d & ~r_filt;

    // Odd parity over data plus parity bit, and stop bit (current sample) high.
    assign w_frame_ok = (^{r_par, r_shift}) & r_dat_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_to_cnt     <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_err        <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bitcnt == 4'd0) begin
                    // Only a low start bit opens a frame.
                    if (!r_dat_s2) begin
                        r_bitcnt <= 4'd1;
                    end
                end else if (r_bitcnt <= 4'd8) begin
                    r_shift  <= {r_dat_s2, r_shift[7:1]};
                    r_bitcnt <= r_bitcnt + 4'd1;
                end else if (r_bitcnt == 4'd9) begin
                    r_par    <= r_dat_s2;
                    r_bitcnt <= 4'd10;
                end else begin
                    r_bitcnt <= 4'd0;
                    if (w_frame_ok) begin
                        r_byte       <= r_shift;
                        r_byte_valid <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end else if (r_bitcnt != 4'd0) begin
                if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    r_bitcnt <= 4'd0;
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;
    assign o_err        = r_err;

endmodule

// File: rtl/kb_scan_fifo.sv
// ---------------------------------------------------------------------------
// kb_scan_fifo -- PS/2 keyboard receiver with prefix decoder and scan FIFO
// for a PicoBlaze read port.
//
// Ports:
//   CLK              system clock
//   RESET_N          asynchronous active-low reset
//   PS2_Clock        raw PS/2 clock
//   PS2_Data         raw PS/2 data
//   Port_ID[7:0]     PicoBlaze port address
//   Read_Strobe      one-cycle read qualifier
//   Keyboard_Output  read data, combinational from Port_ID:
//                      BASE+0 head code (00 if empty), strobe pops
//                      BASE+1 {6'b0, ext, brk} of head
//                      BASE+2 {full, empty, ovf, perr, cnt[3:0]}
//                      BASE+3 ID byte A5, strobe clears ovf/perr
//   Irq              high while the FIFO holds at least one entry
//
// Build option KB_TYPEMATIC_FILTER_EN: when defined, a make code equal to
// the most recent pushed make (same ext and code) with no break since is
// not queued, which suppresses keyboard autorepeat.
//
// Decoder state is held in r_dec_state (dec_state_t) for observation.
// ---------------------------------------------------------------------------
module kb_scan_fifo
    import kb_pkg::*;
#(
    parameter logic [7:0] BASE_PORT   = 8'h10,
    parameter int         DEPTH       = 8,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       PS2_Clock,
    input  logic       PS2_Data,
    input  logic [7:0] Port_ID,
    input  logic       Read_Strobe,
    output logic [7:0] Keyboard_Output,
    output logic       Irq
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [7:0] P_DATA   = BASE_PORT + OFS_DATA;
    localparam logic [7:0] P_FLAGS  = BASE_PORT + OFS_FLAGS;
    localparam logic [7:0] P_STATUS = BASE_PORT + OFS_STATUS;
    localparam logic [7:0] P_CTRL   = BASE_PORT + OFS_CTRL;

    // Receiver outputs
    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_rx_err;

    // Decoder
    dec_state_t r_dec_state;
    dec_state_t w_dec_state_nxt;
    logic       w_dec_push;
    kb_entry_t  w_dec_entry;
    logic       w_push;

    // FIFO
    kb_entry_t  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] w_count;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_wr_en;
    kb_entry_t  w_head;
    logic [3:0] w_cnt4;

    // Sticky flags
    logic       r_ovf;
    logic       r_perr;
    logic       w_ovf_set;
    logic       w_flag_clr;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FILTER_LEN  (FILTER_LEN)
    ) u_rx (
        .i_clk        (CLK),
        .i_rst_n      (RESET_N),
        .i_ps2_clk    (PS2_Clock),
        .i_ps2_data   (PS2_Data),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_err        (w_rx_err)
    );

    // -----------------------------------------------------------------
    // Prefix decoder: E0 and F0 are folded into the following code.
    // -----------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dec_state <= IDLE;
        end else begin
            r_dec_state <= w_dec_state_nxt;
        end
    end

    always_comb begin
        w_dec_state_nxt = r_dec_state;
        w_dec_push      = 1'b0;
        w_dec_entry     = '{ext: 1'b0, brk: 1'b0, code: w_byte};
        if (w_byte_valid) begin
            case (r_dec_state)
                IDLE: begin
                    if (w_byte == PFX_EXT) begin
                        w_dec_state_nxt = EXT;
                    end else if (w_byte == PFX_BRK) begin
                        w_dec_state_nxt = BRK;
                    end else begin
                        w_dec_push = 1'b1;
                    end
                end
                EXT: begin
                    if (w_byte == PFX_BRK) begin
                        w_dec_state_nxt = EXTBRK;
                    end else if (w_byte != PFX_EXT) begin
                        w_dec_push      = 1'b1;
                        w_dec_entry.ext = 1'b1;
                        w_dec_state_nxt = IDLE;
                    end
                end
                BRK: begin
                    w_dec_push      = 1'b1;
                    w_dec_entry.brk = 1'b1;
                    w_dec_state_nxt = IDLE;
                end
                EXTBRK: begin
                    w_dec_push      = 1'b1;
                    w_dec_entry.ext = 1'b1;
                    w_dec_entry.brk = 1'b1;
                    w_dec_state_nxt = IDLE;
                end
                default: w_dec_state_nxt = IDLE;
            endcase
        end
    end

`ifdef KB_TYPEMATIC_FILTER_EN
    // Memory of the last make pushed: {ext, code}.
    logic [8:0] r_last_make;
    logic       r_last_valid;
    logic       w_repeat;

    assign w_repeat = w_dec_push && !w_dec_entry.brk && r_last_valid &&
                      (r_last_make == {w_dec_entry.ext, w_dec_entry.code});
    assign w_push   = w_dec_push && !w_repeat;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_last_make  <= '0;
            r_last_valid <= 1'b0;
        end else if (w_dec_push && w_dec_entry.brk) begin
            r_last_valid <= 1'b0;
        end else if (w_push) begin
            r_last_make  <= {w_dec_entry.ext, w_dec_entry.code};
            r_last_valid <= 1'b1;
        end
    end
`else
    assign w_push = w_dec_push;
`endif

    // -----------------------------------------------------------------
    // FIFO. Pointers carry one extra wrap bit to tell full from empty.
    // -----------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_cnt4  = sat_cnt4(5'(w_count));
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_pop     = Read_Strobe && (Port_ID == P_DATA) && !w_empty;
    // A pop in the same cycle frees the head slot, so a push into a full
    // FIFO is accepted then.
    assign w_wr_en   = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_dec_entry;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------
    // Sticky error flags: a set in the same cycle as a clear wins.
    // -----------------------------------------------------------------
    assign w_flag_clr = Read_Strobe && (Port_ID == P_CTRL);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_flag_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_rx_err) begin
                r_perr <= 1'b1;
            end else if (w_flag_clr) begin
                r_perr <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------
    // Read port
    // -----------------------------------------------------------------
    always_comb begin
        Keyboard_Output = 8'h00;
        if (Port_ID == P_DATA) begin
            Keyboard_Output = w_empty ? 8'h00 : w_head.code;
        end else if (Port_ID == P_FLAGS) begin
            Keyboard_Output = w_empty ? 8'h00 : {6'b0, w_head.ext, w_head.brk};
        end else if (Port_ID == P_STATUS) begin
            Keyboard_Output = {w_full, w_empty, r_ovf, r_perr, w_cnt4};
        end else if (Port_ID == P_CTRL) begin
            Keyboard_Output = ID_BYTE;
        end
    end

    assign Irq = !w_empty;

endmodule

// File: doc/kb_scan_fifo.md
Name: kb_scan_fifo

Overview:
- Parametrised successor to the single-register keyboard path.
- Deserialises PS/2 frames and checks parity and framing.
- Folds E0/F0 prefixes into one decoded entry {ext, brk, code} and buffers entries in a DEPTH-deep FIFO.
- Presents data, flags and status to the PicoBlaze read port at BASE_PORT..BASE_PORT+3; a data-port read pops one entry.

Parameters:
- BASE_PORT, 8'h10, first of four consecutive Port_ID addresses.
- DEPTH, 8, FIFO entries; power of two, 2..16.
- TIMEOUT_CYC, 50000, CLK cycles without a PS/2 falling edge before a partial frame is aborted (1 ms at 50 MHz).
- FILTER_LEN, 3, consecutive equal samples required to accept a new PS2_Clock level.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  reset; one clock; reset is asynchronous and active-low.
- PS2_Clock  in  1  raw keyboard clock, asynchronous.
- PS2_Data  in  1  raw keyboard data, asynchronous.
- Port_ID  in  8  PicoBlaze port address.
- Read_Strobe  in  1  PicoBlaze read qualifier; high for one CLK cycle.
- Keyboard_Output  out  8  read data, combinational from Port_ID.
- Irq  out  1  high while the FIFO is not empty.

Behaviour:
- Reset: FIFO empty, count 0, all sticky flags 0, decoder FSM in IDLE, Irq 0. Keyboard_Output follows its Port_ID decode; at BASE+2 after reset it reads 8'h40.
- Input sync: 2-FF synchronisers on both PS/2 lines. PS2_Clock is then glitch-filtered: it changes only after FILTER_LEN equal samples. A filtered falling edge samples PS2_Data.
- Frame: 11 bits, LSB first: start 0, 8 data, odd parity, stop 1.
  - Bad start: frame discarded; bit counter restarts.
  - Parity or stop error: byte dropped; sticky perr set.
  - Timeout: if TIMEOUT_CYC cycles pass between edges with bit counter ≠ 0, counter clears; no flag.
- Decoder FSM, run once per good byte:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> push {0,0,byte}, stay in IDLE.
  - EXT: F0 -> EXTBRK; E0 -> stay in EXT; any other byte -> push {1,0,byte}, go to IDLE.
  - BRK: push {0,1,byte}, go to IDLE.
  - EXTBRK: push {1,1,byte}, go to IDLE.
  - Byte AA or FA while in IDLE is pushed as a normal code.
- FIFO: 10-bit entries; write/read pointers of log2(DEPTH)+1 bits.
  - Full = MSBs differ and low bits equal.
  - Push when full: entry dropped, sticky ovf set, contents unchanged.
  - Push and pop in the same cycle: both take effect, count unchanged, legal even when full.
  - Pop when empty: ignored.
- Read map (Keyboard_Output):
  - BASE+0: head code[7:0], or 8'h00 if empty. Read_Strobe at this address pops the head at the end of the cycle, so the next cycle shows the new head.
  - BASE+1: {6'b0, ext, brk} of head; no pop.
  - BASE+2: {full, empty, ovf, perr, cnt[3:0]}. cnt saturates at 15.
  - BASE+3: 8'hA5 ID byte. Read_Strobe here clears ovf and perr. A simultaneous set wins over the clear.
  - Any other Port_ID: 8'h00, and Read_Strobe has no effect.
- Latency: stop-bit falling edge -> entry visible at head in ≤4 CLK cycles when the FIFO is empty.
- Reset mid-frame: partial frame and pending prefix state are lost; FIFO is cleared.

Optional Feature:
- Macro KB_TYPEMATIC_FILTER_EN.
- Defined: a make entry equal to the last pushed make of the same {ext, code}, with no intervening break, is not pushed, so autorepeat is suppressed. Any break clears the memory. Reset clears the memory.
- Undefined: every decoded make is pushed, including typematic repeats.

Decomposition:
- Package kb_pkg holds:
  - Port offsets: OFS_DATA=0, OFS_FLAGS=1, OFS_STATUS=2, OFS_CTRL=3.
  - Prefix constants: 8'hE0, 8'hF0.
  - ID byte 8'hA5.
  - Decoder state enum: IDLE, EXT, BRK, EXTBRK.
  - 10-bit entry struct.
- Sub-module ps2_frame_rx: sync, filter, 11-bit shift, parity check, timeout. Outputs byte, byte_valid pulse and err pulse.
- The FIFO and decoder live in the top block.

Test Plan:
- Send 1C (A) -> BASE+0 reads 1C, BASE+1 reads 00, BASE+2 reads 01; Read_Strobe at BASE+0 -> BASE+2 reads 40.
- Send E0 F0 75 -> one entry; BASE+0 reads 75, BASE+1 reads 03.
- Send 9 codes with DEPTH=8 and no reads -> BASE+2 reads A8. Read_Strobe at BASE+3 -> BASE+2 reads 88, and the first 8 codes pop in order.
- Send a frame with bad parity for 1C -> no entry; BASE+2 reads 50.
- Send start plus 4 bits, idle TIMEOUT_CYC+10 cycles, then a full frame for 29 -> only 29 is queued, no error flag.
- Send 1C 1C 1C F0 1C -> with KB_TYPEMATIC_FILTER_EN, entries are 1C(make) and 1C(brk), count 2. Without it, count 4. Also: a pop and an arriving push in the same cycle with the FIFO full -> count stays 8, ovf stays 0.
